// File: rtl/rng_pkg.sv
// Shared timing constants for the Mersenne-Twister rng and its consumers,
// plus the prefetcher FSM state type.
package rng_pkg;

  localparam int unsigned N            = 624;
  localparam int unsigned BOOT_CYCLES  = 1248;
  localparam int unsigned TWIST_CYCLES = 624;
  localparam int unsigned RNG_LAT      = 5;

  localparam int unsigned WAIT_W = $clog2(BOOT_CYCLES + 1);
  localparam int unsigned LAT_W  = $clog2(RNG_LAT + 1);
  localparam int unsigned BLK_W  = $clog2(N);

  typedef enum logic [1:0] {
    StBoot,
    StIdle,
    StLat,
    StTwist
  } pf_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with occupancy output; head reads as zero while empty.
module sync_fifo #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned LG_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push_i,
  input  logic [WIDTH-1:0]    push_data_i,
  input  logic                pop_i,
  output logic [WIDTH-1:0]    head_o,
  output logic                valid_o,
  output logic [LG_DEPTH:0]   level_o
);

  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [LG_DEPTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [LG_DEPTH:0]   level_q;
  logic                do_push, do_pop;

  assign do_pop  = pop_i && (level_q != '0);
  assign do_push = push_i && (level_q != DEPTH[LG_DEPTH:0]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + LG_DEPTH'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + LG_DEPTH'(1);
      if (do_push && !do_pop) begin
        level_q <= level_q + (LG_DEPTH + 1)'(1);
      end else if (do_pop && !do_push) begin
        level_q <= level_q - (LG_DEPTH + 1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = (level_q == '0) ? '0 : mem_q[rd_ptr_q];
  assign valid_o = (level_q != '0);
  assign level_o = level_q;

endmodule

// File: rtl/rng_prefetch.sv
// Paces request pulses to the handshake-less MT rng (boot, latency, re-twist),
// buffers fresh words in a FIFO and serves them with a range-scaled view.
module rng_prefetch
  import rng_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned LG_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         rng_random,
  output logic                rng_new_number,
  input  logic [15:0]         range,
  input  logic                rd_ready,
  output logic                rd_valid,
  output logic [31:0]         rd_raw,
  output logic [15:0]         rd_data,
  output logic [LG_DEPTH:0]   level
);

  pf_state_e         state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [BLK_W-1:0]  blk_q, blk_d;
  logic              new_q, new_d;
  logic              push, pop, enter_idle, free_nxt;
  logic [LG_DEPTH:0] level_nxt;

  assign pop = rd_valid && rd_ready;

  // Occupancy as it will be next cycle, so the registered pulse lands in the IDLE cycle.
  always_comb begin
    level_nxt = level;
    if (push && !pop) begin
      level_nxt = level + (LG_DEPTH + 1)'(1);
    end else if (pop && !push) begin
      level_nxt = level - (LG_DEPTH + 1)'(1);
    end
    free_nxt = (level_nxt < DEPTH[LG_DEPTH:0]);
  end

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    lat_d      = lat_q;
    blk_d      = blk_q;
    push       = 1'b0;
    enter_idle = 1'b0;
    unique case (state_q)
      StBoot: begin
        wait_d = wait_q - WAIT_W'(1);
        if (wait_q == WAIT_W'(1)) enter_idle = 1'b1;
      end
      StIdle: begin
        if (new_q) begin
          state_d = StLat;
          lat_d   = LAT_W'(RNG_LAT - 1);
        end else begin
          enter_idle = 1'b1;
        end
      end
      StLat: begin
        if (lat_q == '0) begin
          push = 1'b1;
          if (blk_q == BLK_W'(N - 1)) begin
            blk_d   = '0;
            state_d = StTwist;
            wait_d  = WAIT_W'(TWIST_CYCLES - 1);
          end else begin
            blk_d      = blk_q + BLK_W'(1);
            enter_idle = 1'b1;
          end
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      StTwist: begin
        if (wait_q == '0) begin
          enter_idle = 1'b1;
        end else begin
          wait_d = wait_q - WAIT_W'(1);
        end
      end
    endcase
    if (enter_idle) state_d = StIdle;
    new_d = enter_idle && free_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StBoot;
      wait_q  <= WAIT_W'(BOOT_CYCLES);
      lat_q   <= '0;
      blk_q   <= '0;
      new_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      lat_q   <= lat_d;
      blk_q   <= blk_d;
      new_q   <= new_d;
    end
  end

  assign rng_new_number = new_q;

  sync_fifo #(
    .WIDTH    (32),
    .DEPTH    (DEPTH),
    .LG_DEPTH (LG_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_data_i (rng_random),
    .pop_i       (rd_ready),
    .head_o      (rd_raw),
    .valid_o     (rd_valid),
    .level_o     (level)
  );

  assign rd_data = 16'((32'(rd_raw[31:16]) * 32'(range)) >> 16);

endmodule

// File: tb/tb_rng_prefetch.sv
// Bench for rng_prefetch: MT19937 rng model with boot/latency/twist timing,
// a scoreboard of issued words, and table-driven scaling vectors.
module tb_rng_prefetch;
  import rng_pkg::*;

  localparam int unsigned DEPTH    = 4;
  localparam int unsigned LG_DEPTH = 2;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [31:0]         rng_random = '0;
  logic                rng_new_number;
  logic [15:0]         range = '0;
  logic                rd_ready = 1'b0;
  logic                rd_valid;
  logic [31:0]         rd_raw;
  logic [15:0]         rd_data;
  logic [LG_DEPTH:0]   level;

  rng_prefetch #(
    .DEPTH    (DEPTH),
    .LG_DEPTH (LG_DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rng_random     (rng_random),
    .rng_new_number (rng_new_number),
    .range          (range),
    .rd_ready       (rd_ready),
    .rd_valid       (rd_valid),
    .rd_raw         (rd_raw),
    .rd_data        (rd_data),
    .level          (level)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", name, act, act, exp, exp);
    end
  endtask

  // Golden MT19937
  int unsigned mt [624];
  int          mti;

  function automatic void mt_seed(input int unsigned s);
    mt[0] = s;
    for (int i = 1; i < 624; i++) begin
      mt[i] = 32'd1812433253 * (mt[i-1] ^ (mt[i-1] >> 30)) + i;
    end
    mti = 624;
  endfunction

  function automatic int unsigned mt_next();
    int unsigned y;
    if (mti >= 624) begin
      for (int k = 0; k < 624; k++) begin
        y = (mt[k] & 32'h8000_0000) | (mt[(k + 1) % 624] & 32'h7fff_ffff);
        mt[k] = mt[(k + 397) % 624] ^ (y >> 1) ^ (y[0] ? 32'h9908_b0df : 32'h0);
      end
      mti = 0;
    end
    y = mt[mti];
    mti++;
    y = y ^ (y >> 11);
    y = y ^ ((y << 7) & 32'h9d2c_5680);
    y = y ^ ((y << 15) & 32'hefc6_0000);
    y = y ^ (y >> 18);
    return y;
  endfunction

  typedef struct {
    logic [31:0] raw;
    logic [15:0] bound;
    logic [15:0] exp_data;
  } vec_t;

  localparam int NV = 6;
  vec_t vecs [NV];

  // rng timing model + scoreboard
  int          cyc = 0;
  int          pulse_cnt = 0;
  int          next_ok = BOOT_CYCLES;
  int          last_pulse = -1;
  int          deliver_at = -1;
  int          t_block_end = -1;
  int          t_after_twist = -1;
  int          pops = 0;
  int          tbl_idx = 0;
  bit          exact = 1'b0;
  bit          table_mode = 1'b0;
  logic [31:0] pending = '0;
  logic [31:0] sb [$];
  logic [31:0] popped [$];

  always @(posedge clk) begin
    if (!rst_n) begin
      cyc = 0;
    end else begin
      if (rng_new_number) begin
        pulse_cnt++;
        chk("pulse_not_early", (cyc >= next_ok) ? 32'd1 : 32'd0, 32'd1);
        if (exact) chk("pulse_time", cyc, next_ok);
        next_ok = ((pulse_cnt % N) == 0) ? cyc + RNG_LAT + TWIST_CYCLES + 1 : cyc + RNG_LAT + 1;
        if (pulse_cnt == N)     t_block_end   = cyc;
        if (pulse_cnt == N + 1) t_after_twist = cyc;
        last_pulse = cyc;
        if (table_mode && tbl_idx < NV) begin
          pending = vecs[tbl_idx].raw;
          tbl_idx++;
        end else begin
          pending = mt_next();
        end
        sb.push_back(pending);
        deliver_at = cyc + RNG_LAT;
      end
      if (rd_valid && rd_ready) begin
        pops++;
        popped.push_back(rd_raw);
        if (sb.size() == 0) chk("pop_without_word", 32'd1, 32'd0);
        else                chk("rd_raw_order", rd_raw, sb.pop_front());
      end
      cyc++;
    end
  end

  always @(negedge clk) begin
    if (rst_n && cyc == deliver_at) rng_random = pending;
  end

  task automatic restart_rng();
    mt_seed(32'd5489);
    pulse_cnt     = 0;
    next_ok       = BOOT_CYCLES;
    deliver_at    = -1;
    t_block_end   = -1;
    t_after_twist = -1;
    rng_random    = '0;
    sb.delete();
  endtask

  initial begin
    int pc;
    vecs[0] = '{32'hFFFF_0000, 16'd100,    16'd99};
    vecs[1] = '{32'hFFFF_0000, 16'd0,      16'd0};
    vecs[2] = '{32'h8000_0000, 16'd10,     16'd5};
    vecs[3] = '{32'h0000_FFFF, 16'd1000,   16'd0};
    vecs[4] = '{32'h1234_0000, 16'hFFFF,   16'h1233};
    vecs[5] = '{32'hFFFF_FFFF, 16'hFFFF,   16'hFFFE};

    // Boot with rd_ready low
    restart_rng();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_rd_valid", rd_valid, 0);
    chk("reset_level", level, 0);
    chk("reset_rd_raw", rd_raw, 0);
    chk("reset_rd_data", rd_data, 0);
    chk("reset_pulse", rng_new_number, 0);
    rst_n = 1'b1;
    exact = 1'b1;
    for (int i = 0; i < 2000 && pulse_cnt < 4; i++) @(negedge clk);
    chk("boot_four_pulses", pulse_cnt, 4);
    exact = 1'b0;
    repeat (20) @(negedge clk);
    chk("boot_pulses_stop", pulse_cnt, 4);
    chk("boot_level_full", level, 4);
    chk("boot_rd_valid", rd_valid, 1);
    chk("boot_first_word", rd_raw, 32'd3499211612);

    // Continuous drain across a twist boundary
    range = 16'd1000;
    rd_ready = 1'b1;
    pc = pulse_cnt;
    for (int i = 0; i < 50 && pulse_cnt == pc; i++) @(negedge clk);
    chk("resume_pulse", (pulse_cnt > pc) ? 32'd1 : 32'd0, 32'd1);
    exact = 1'b1;
    for (int i = 0; i < 6000 && pops < 630; i++) @(negedge clk);
    rd_ready = 1'b0;
    exact = 1'b0;
    chk("drain_630_words", (pops >= 630) ? 32'd1 : 32'd0, 32'd1);
    chk("golden_word0", popped[0], 32'd3499211612);
    chk("golden_word1", popped[1], 32'd581869302);
    chk("golden_word2", popped[2], 32'd3890346734);
    chk("twist_gap", t_after_twist - t_block_end, RNG_LAT + TWIST_CYCLES + 1);

    // Push and pop together at level 3
    for (int i = 0; i < 100 && level != 4; i++) @(negedge clk);
    chk("refill_level", level, 4);
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
    pc = pulse_cnt;
    for (int i = 0; i < 20 && pulse_cnt == pc; i++) @(negedge clk);
    chk("pulse_after_pop", (pulse_cnt > pc) ? 32'd1 : 32'd0, 32'd1);
    for (int i = 0; i < 20 && cyc != last_pulse + RNG_LAT; i++) @(negedge clk);
    chk("pushpop_pre_level", level, 3);
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
    chk("pushpop_level", level, 3);

    // Reset mid-stream with rng restart; table words follow
    rst_n = 1'b0;
    restart_rng();
    table_mode = 1'b1;
    tbl_idx = 0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midreset_level", level, 0);
    chk("midreset_rd_valid", rd_valid, 0);
    chk("midreset_pulse", rng_new_number, 0);
    rd_ready = 1'b1;
    repeat (10) @(negedge clk);
    rd_ready = 1'b0;
    chk("empty_pop_level", level, 0);
    chk("empty_pop_valid", rd_valid, 0);
    exact = 1'b1;
    for (int i = 0; i < 1400 && pulse_cnt < 1; i++) @(negedge clk);
    chk("reboot_pulse", pulse_cnt, 1);
    exact = 1'b0;

    for (int v = 0; v < NV; v++) begin
      for (int i = 0; i < 50 && !rd_valid; i++) @(negedge clk);
      range = vecs[v].bound;
      #1;
      chk("scale_rd_raw", rd_raw, vecs[v].raw);
      chk("scale_rd_data", {16'h0, rd_data}, {16'h0, vecs[v].exp_data});
      @(negedge clk);
      rd_ready = 1'b1;
      @(negedge clk);
      rd_ready = 1'b0;
    end

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rng_prefetch.md
Name: rng_prefetch

Overview:
- Sits directly downstream of the Mersenne-Twister rng block, which has no valid/ready handshake.
- Issues single-cycle new_number pulses at times the rng can accept them. Tracks rng boot, generate latency and re-twist timing so every captured word is fresh.
- Buffers captured words in a small FIFO and presents them to game logic (obstacle/spawn placement) through a valid/ready port.
- Provides a range-scaled value alongside the raw word.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- LG_DEPTH, 2, log2(DEPTH).
- BOOT_CYCLES, 1248, cycles from rst_n release until the rng first reaches WAIT (624 seed + 624 twist).
- RNG_LAT, 5, cycles from a pulse to the new value appearing on rng_random.
- TWIST_CYCLES, 624, cycles the rng spends re-twisting after each block of N outputs.
- N, 624, outputs per twist block.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- rng_random  in  32  rng output word.
- rng_new_number  out  1  single-cycle request pulse to the rng.
- range  in  16  scale bound for rd_data; 0 is legal.
- rd_ready  in  1  consumer accepts the head entry.
- rd_valid  out  1  FIFO non-empty.
- rd_raw  out  32  head entry, raw.
- rd_data  out  16  (rd_raw[31:16] * range) >> 16; always < range when range > 0.
- level  out  LG_DEPTH+1  current FIFO occupancy.

Behaviour:
- Reset (rst_n low at a clk edge): state=BOOT, wait counter=BOOT_CYCLES, block-output counter=0, FIFO empty, rng_new_number=0, rd_valid=0, level=0. rd_raw and rd_data show 0 while empty.
- rst_n release must coincide with rng power-up. A reset mid-operation is legal only if the rng is restarted in the same cycle; otherwise synchronisation is lost and behaviour is undefined.
- State BOOT:
  - Decrement the wait counter each cycle.
  - At 0, go to IDLE. The first legal pulse is in cycle BOOT_CYCLES after release.
- State IDLE:
  - If level + 0 in flight < DEPTH, drive rng_new_number=1 for exactly this cycle and go to LAT with lat counter=RNG_LAT-1.
  - Otherwise stay in IDLE; rng_new_number=0.
- State LAT:
  - rng_new_number=0. Count down.
  - In the cycle the counter hits 0 (RNG_LAT cycles after the pulse), capture rng_random into the FIFO and increment the block-output counter.
  - If the counter was N-1: reset it to 0 and go to TWIST with wait=TWIST_CYCLES-1.
  - Otherwise go to IDLE. A back-to-back pulse is allowed in the next cycle, giving a throughput of 1 word per RNG_LAT+1 cycles.
- State TWIST: count down, then go to IDLE. The next pulse occurs exactly RNG_LAT+TWIST_CYCLES+1 cycles after the 624th pulse.
- Only one request is ever in flight. A capture can never hit a full FIFO, because the request is issued only when a slot is free.
- FIFO:
  - Pop when rd_valid && rd_ready.
  - Push and pop in the same cycle leaves level unchanged, with correct ordering.
  - Push into an empty FIFO makes rd_valid rise the next cycle; there is no bypass.
  - Pointers wrap modulo DEPTH.
  - rd_ready while empty is ignored.
- rd_data is combinational from the head entry and range: a 16x16 multiply keeping bits [31:16]. range=0 gives rd_data=0.
- All outputs except rd_data are registered.

Decomposition:
- Shared package rng_pkg holds:
  - N, BOOT_CYCLES, TWIST_CYCLES and RNG_LAT, so the rng and this block share one source of truth.
  - The state enum {BOOT, IDLE, LAT, TWIST}.
- One sub-module, sync_fifo (parameterised width/depth, push/pop/level), reusable elsewhere in the game pipeline.
- The scaling multiply stays inline.

Test Plan:
- Boot: release rst_n with the real rng, seed=5489, rd_ready=0 → first rng_new_number in cycle 1248. rd_raw = 3499211612 (MT19937 first output for seed 5489). level reaches 4 after 4 pulses spaced 6 cycles apart, then pulses stop.
- Drain/refill: rd_ready=1 continuously → rd_raw sequence 3499211612, 581869302, 3890346734, … matches the golden MT19937 model. Exactly one pulse per 6 cycles in steady state.
- Twist boundary: consume 630 words → the pulse after the 624th is delayed by exactly 624 extra cycles. Word 625 matches the golden model (no duplicate, no stale value).
- Scaling: head=0xFFFF0000 with range=100 → rd_data=99. range=0 → 0. Head=0x80000000 with range=10 → 5.
- Simultaneous push/pop at level=3 → level stays 3 and pop order is preserved. rd_ready with level=0 → no underflow, level stays 0.
- Reset mid-stream: assert rst_n=0 for 1 cycle together with an rng restart → level=0, rd_valid=0, and the next pulse comes 1248 cycles after release.
